alu_iter: RTL and testbench

Parametrised successor to the execute-stage ALU. It registers every result and adds an iterative multiply/divide unit (MUL, DIVU, REMU) behind a valid/ready handshake, so the EX stage stalls on `IN_READY` while a long operation runs. Opcodes 1–12 keep their existing encoding and meaning, generalised to `WIDTH` bits.

---
 rtl/alu_iter.sv | 178 +++++++++++++++++
 tb/tb_alu_iter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - registered execute-stage ALU with optional iterative MUL/DIVU/REMU unit
//
// Optional feature macro: ALU_MULDIV_EN (builds the iterative multiply/divide datapath).
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset
//   IN_VALID   in   operation presented
//   IN_READY   out  operation can be accepted (state IDLE)
//   FLUSH      in   abort accepted / in-flight operation
//   ALUOP      in   4-bit opcode
//   SRC1       in   operand A
//   SRC2       in   operand B
//   OUT_VALID  out  one-cycle pulse marking a new ALUOUT
//   ALUOUT     out  result register
//   BUSY       out  iterative operation in progress
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             FLUSH,
    input  logic [3:0]       ALUOP,
    input  logic [WIDTH-1:0] SRC1,
    input  logic [WIDTH-1:0] SRC2,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] ALUOUT,
    output logic             BUSY
);

    // Captured operands/opcode. For iterative ops reg_a doubles as the
    // multiplicand (MUL) or the dividend-shifting-into-quotient (DIVU/REMU),
    // and reg_b as the multiplier or divisor.
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [3:0]       op_q;
    logic             pend;      // single-cycle op captured, result due next edge
    logic             accept;
    logic [WIDTH-1:0] simple_res;
    logic [SHW-1:0]   sh;
    logic [2*WIDTH-1:0] rot_wide;

    assign accept   = IN_VALID && IN_READY && !FLUSH;
    assign sh       = reg_b[SHW-1:0];
    // Rotating a doubled copy gives rotate-right without a special case for sh=0.
    assign rot_wide = {reg_a, reg_a} >> sh;

    always_comb begin
        simple_res = '0;
        case (op_q)
            4'd1:    simple_res = reg_a + reg_b;
            4'd2:    simple_res = reg_a - reg_b;
            4'd3:    simple_res = -reg_b;
            4'd4:    simple_res = ~reg_b;
            4'd5:    simple_res = reg_a & reg_b;
            4'd6:    simple_res = reg_a | reg_b;
            4'd7:    simple_res = reg_a ^ reg_b;
            4'd8:    simple_res = reg_a >> sh;
            4'd9:    simple_res = $signed(reg_a) >>> sh;
            4'd10:   simple_res = reg_a << sh;
            4'd11:   simple_res = rot_wide[WIDTH-1:0];
            4'd12:   simple_res = reg_b;
            default: simple_res = '0;   // 0, and 13-15 when the iterative unit is absent
        endcase
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] acc;       // product (MUL) or partial remainder (DIVU/REMU)

    logic [WIDTH-1:0] mul_next;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign IN_READY = (state == S_IDLE);
    assign BUSY     = (state == S_BUSY);

    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits. A zero divisor always
    // "fits", which yields an all-ones quotient and remainder == dividend.
    assign mul_next  = acc + (reg_b[0] ? reg_a : '0);
    assign div_trial = {acc, reg_a[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, reg_b};
    assign div_ge    = (div_trial >= {1'b0, reg_b});
    assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign quo_next  = {reg_a[WIDTH-2:0], div_ge};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            count     <= '0;
            acc       <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            op_q      <= '0;
            pend      <= 1'b0;
            ALUOUT    <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (pend && !FLUSH) begin
                ALUOUT    <= simple_res;
                OUT_VALID <= 1'b1;
            end
            pend <= accept && (ALUOP < 4'd13);

            if (FLUSH) begin
                state <= S_IDLE;
                count <= '0;
            end else if (state == S_BUSY) begin
                count <= count + 1'b1;
                if (op_q[1:0] == 2'b01) begin
                    acc   <= mul_next;
                    reg_a <= reg_a << 1;
                    reg_b <= reg_b >> 1;
                end else begin
                    acc   <= rem_next;
                    reg_a <= quo_next;
                end
                if (count == SHW'(WIDTH - 1)) begin
                    state     <= S_IDLE;
                    OUT_VALID <= 1'b1;
                    case (op_q[1:0])
                        2'b01:   ALUOUT <= mul_next;
                        2'b10:   ALUOUT <= quo_next;
                        default: ALUOUT <= rem_next;
                    endcase
                end
            end else if (accept) begin
                reg_a <= SRC1;
                reg_b <= SRC2;
                op_q  <= ALUOP;
                if (ALUOP >= 4'd13) begin
                    acc   <= '0;
                    count <= '0;
                    state <= S_BUSY;
                end
            end
        end
    end
`else
    assign IN_READY = 1'b1;
    assign BUSY     = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_a     <= '0;
            reg_b     <= '0;
            op_q      <= '0;
            pend      <= 1'b0;
            ALUOUT    <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (pend && !FLUSH) begin
                ALUOUT    <= simple_res;
                OUT_VALID <= 1'b1;
            end
            pend <= accept;
            if (accept) begin
                reg_a <= SRC1;
                reg_b <= SRC2;
                op_q  <= ALUOP;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed self-checking bench for alu_iter
module tb_alu_iter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        FLUSH = 1'b0;
    logic [3:0]  ALUOP = 4'd0;
    logic [31:0] SRC1 = 32'd0;
    logic [31:0] SRC2 = 32'd0;
    logic        OUT_VALID;
    logic [31:0] ALUOUT;
    logic        BUSY;

    int checks = 0;
    int failures = 0;

    alu_iter #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .FLUSH(FLUSH), .ALUOP(ALUOP), .SRC1(SRC1), .SRC2(SRC2),
        .OUT_VALID(OUT_VALID), .ALUOUT(ALUOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        IN_VALID = v;
        ALUOP    = op;
        SRC1     = a;
        SRC2     = b;
    endtask

    // Present one single-cycle op, then check result one edge after acceptance.
    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        drive(1'b1, op, a, b);
        step();
        drive(1'b0, 4'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step();
        check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
        check(tag, ALUOUT, exp);
    endtask

`ifdef ALU_MULDIV_EN
    // Iterative op: result must arrive exactly 32 edges after acceptance with
    // IN_READY low in every cycle in between. Operands are scrambled after
    // acceptance to show they were captured.
    task automatic iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int low;
        lat = 0;
        low = 0;
        drive(1'b1, op, a, b);
        step();
        drive(1'b0, 4'd1, 32'h1234_5678, 32'h0000_0001);
        while (!OUT_VALID && lat < 100) begin
            if (!IN_READY && BUSY) low++;
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd32);
        check({tag, "_notready"}, low, 32'd32);
        check(tag, ALUOUT, exp);
        check({tag, "_ready_back"}, {31'd0, IN_READY}, 32'd1);
    endtask
`endif

    initial begin
        int seen;
        // Reset
        step();
        step();
        RST = 1'b0;
        check("rst_aluout", ALUOUT, 32'd0);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);

        // Back-to-back ops 1, 2, 11
        drive(1'b1, 4'd1, 32'h8000_0001, 32'd4);
        step();
        drive(1'b1, 4'd2, 32'h8000_0001, 32'd4);
        step();
        check("b2b_add_valid", {31'd0, OUT_VALID}, 32'd1);
        check("b2b_add", ALUOUT, 32'h8000_0005);
        drive(1'b1, 4'd11, 32'h8000_0001, 32'd4);
        step();
        check("b2b_sub_valid", {31'd0, OUT_VALID}, 32'd1);
        check("b2b_sub", ALUOUT, 32'h7FFF_FFFD);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        check("b2b_ror_valid", {31'd0, OUT_VALID}, 32'd1);
        check("b2b_ror", ALUOUT, 32'h1800_0000);
        step();
        check("pulse_one_cycle", {31'd0, OUT_VALID}, 32'd0);
        check("aluout_hold", ALUOUT, 32'h1800_0000);

        // Shifts and remaining single-cycle ops
        single("sra", 4'd9, 32'hF000_0000, 32'd4, 32'hFF00_0000);
        single("srl", 4'd8, 32'hF000_0000, 32'd4, 32'h0F00_0000);
        single("ror0", 4'd11, 32'hF000_0000, 32'd0, 32'hF000_0000);
        single("sll", 4'd10, 32'h0000_0F01, 32'h0000_0104, 32'h0000_F010);
        single("neg", 4'd3, 32'h5555_5555, 32'd1, 32'hFFFF_FFFF);
        single("not", 4'd4, 32'd0, 32'h0F0F_0000, 32'hF0F0_FFFF);
        single("and", 4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        single("or", 4'd6, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF);
        single("xor", 4'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        single("passb", 4'd12, 32'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        single("op0", 4'd0, 32'h1111_1111, 32'h2222_2222, 32'd0);
        single("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'd2, 32'd1);

        // FLUSH beats acceptance in the same cycle
        drive(1'b1, 4'd12, 32'd0, 32'hAAAA_AAAA);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        check("flush_accept_valid", {31'd0, OUT_VALID}, 32'd0);
        check("flush_accept_hold", ALUOUT, 32'd1);

        // FLUSH kills a single-cycle op already accepted
        drive(1'b1, 4'd12, 32'd0, 32'hBBBB_BBBB);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("flush_pend_valid", {31'd0, OUT_VALID}, 32'd0);
        check("flush_pend_hold", ALUOUT, 32'd1);

`ifdef ALU_MULDIV_EN
        iter("mul", 4'd13, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        iter("divu", 4'd14, 32'd100, 32'd7, 32'd14);
        iter("remu", 4'd15, 32'd100, 32'd7, 32'd2);
        iter("divu_zero", 4'd14, 32'd5, 32'd0, 32'hFFFF_FFFF);
        iter("remu_zero", 4'd15, 32'd5, 32'd0, 32'd5);

        // FLUSH mid-division
        drive(1'b1, 4'd14, 32'd100, 32'd7);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) step();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("flush_div_ready", {31'd0, IN_READY}, 32'd1);
        check("flush_div_busy", {31'd0, BUSY}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (OUT_VALID) seen++;
            step();
        end
        check("flush_div_no_valid", seen, 32'd0);
        check("flush_div_hold", ALUOUT, 32'd5);

        // RST mid-division
        drive(1'b1, 4'd14, 32'd100, 32'd7);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_div_ready", {31'd0, IN_READY}, 32'd1);
        check("rst_div_aluout", ALUOUT, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (OUT_VALID) seen++;
            step();
        end
        check("rst_div_no_valid", seen, 32'd0);
`else
        // Iterative opcodes degrade to single-cycle zero results
        single("seed", 4'd12, 32'd0, 32'h0000_00AB, 32'h0000_00AB);
        drive(1'b1, 4'd13, 32'd6, 32'd7);
        check("nomd_ready_pre", {31'd0, IN_READY}, 32'd1);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check("nomd_ready_mid", {31'd0, IN_READY}, 32'd1);
        check("nomd_busy", {31'd0, BUSY}, 32'd0);
        step();
        check("nomd_mul_valid", {31'd0, OUT_VALID}, 32'd1);
        check("nomd_mul", ALUOUT, 32'd0);
        check("nomd_ready_post", {31'd0, IN_READY}, 32'd1);
        single("nomd_divu", 4'd14, 32'd100, 32'd7, 32'd0);
        single("nomd_remu", 4'd15, 32'd100, 32'd7, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
